shift_chain_ctrl: RTL and testbench

- Controller that sequences a WIDTH-bit chain of edge-triggered D flip-flops as a parallel-in, serial-out shifter.
- Accepts a parallel word on a valid/ready load port and parks it in the chain.
- Streams the word out LSB-first on a valid/ready serial port, one bit per accepted handshake, then pulses done.
- Sits between a word-level producer and a bit-serial consumer.

---
 rtl/shift_chain_pkg.sv | 13 +
 rtl/shift_chain.sv | 30 +++
 rtl/shift_chain_ctrl.sv | 134 +++++++++++++
 tb/tb_shift_chain_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/shift_chain_pkg.sv
// Shared types for the shift-chain serializer: FSM state encoding and default word length.
package shift_chain_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_chain.sv
// WIDTH-bit D flip-flop chain with async clear, parallel load and right shift (zero fill at MSB).
module shift_chain
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_en,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_chain;

  // Load wins over shift; the controller never asserts both in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else if (i_load_en) begin
      r_chain <= i_load_data;
    end else if (i_shift_en) begin
      r_chain <= {1'b0, r_chain[WIDTH-1:1]};
    end
  end

  assign o_lsb = r_chain[0];

endmodule

// File: rtl/shift_chain_ctrl.sv
// Parallel-in, serial-out controller: accepts a word, streams it LSB-first, pulses done.
// Optional trailing even-parity bit when SHIFT_CHAIN_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for a word, load_ready high
// SHIFT | streaming data bits from chain[0]
// PAR   | presenting the parity bit (parity build only)
// DONE  | one-cycle done pulse, then back to IDLE
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_load_ready;
  logic             r_ser_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_load_en;
  logic             w_shift_en;
  logic             w_lsb;

  assign w_load_en  = (r_state == IDLE) && r_load_ready && load_valid;
  assign w_shift_en = (r_state == SHIFT) && ser_ready;

  shift_chain #(.WIDTH(WIDTH)) u_chain (
    .clk        (clk),
    .rst        (rst),
    .i_load_en  (w_load_en),
    .i_shift_en (w_shift_en),
    .i_load_data(load_data),
    .o_lsb      (w_lsb)
  );

`ifdef SHIFT_CHAIN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load_en) begin
      r_parity <= ^load_data;
    end
  end

  assign ser_out = (r_state == SHIFT) ? w_lsb : ((r_state == PAR) ? r_parity : 1'b0);
`else
  assign ser_out = (r_state == SHIFT) && w_lsb;
`endif

  // load_ready is registered, so it first rises on the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_load_ready <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_en) begin
            r_state      <= SHIFT;
            r_cnt        <= '0;
            r_load_ready <= 1'b0;
            r_ser_valid  <= 1'b1;
            r_busy       <= 1'b1;
          end else begin
            r_load_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
`ifdef SHIFT_CHAIN_PARITY_EN
              r_state <= PAR;
`else
              r_state     <= DONE;
              r_ser_valid <= 1'b0;
              r_done      <= 1'b1;
`endif
            end
          end
        end
`ifdef SHIFT_CHAIN_PARITY_EN
        PAR: begin
          if (ser_ready) begin
            r_state     <= DONE;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        DONE: begin
          r_state      <= IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_ser_valid  <= 1'b0;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign ser_valid  = r_ser_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed + randomized bench for shift_chain_ctrl against a word-level bit-stream model.
module tb_shift_chain_ctrl;

  localparam int WIDTH = 8;
`ifdef SHIFT_CHAIN_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_data = '0;
  logic             ser_valid;
  logic             ser_ready = 1'b0;
  logic             ser_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_chain_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit k of the stream is word bit k; the optional last bit is even parity of the word.
  function automatic logic exp_bit(input logic [WIDTH-1:0] word, input int k);
    if (k < WIDTH) return logic'((word >> k) & 1);
    return logic'($countones(word) % 2);
  endfunction

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1 repeating, 2 = random ready
  task automatic run_word(input logic [WIDTH-1:0] word, input int mode,
                          input logic hold_valid, input logic [WIDTH-1:0] hold_data);
    int  idx = 0;
    int  cyc = 0;
    logic r;
    chk("idle_ready", load_ready, 1);
    chk("idle_ser_valid", ser_valid, 0);
    chk("idle_busy", busy, 0);
    load_valid = 1'b1;
    load_data  = word;
    tick();
    if (hold_valid) begin
      load_data = hold_data;
    end else begin
      load_valid = 1'b0;
      load_data  = WIDTH'($urandom);
    end
    while (idx < NBITS && cyc < 400) begin
      chk("ser_valid", ser_valid, 1);
      chk("ser_out", ser_out, exp_bit(word, idx));
      chk("busy_xfer", busy, 1);
      chk("ready_xfer", load_ready, 0);
      chk("done_early", done, 0);
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
      else r = logic'($urandom_range(0, 1));
      ser_ready = r;
      tick();
      if (r) idx++;
      cyc++;
    end
    chk("bits_sent", idx, NBITS);
    ser_ready = logic'($urandom_range(0, 1));
    chk("done_pulse", done, 1);
    chk("done_ser_valid", ser_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_ready", load_ready, 0);
    tick();
    chk("post_done", done, 0);
    chk("post_ready", load_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_ready", load_ready, 1);
    chk("rel_ser_valid", ser_valid, 0);

    // Basic word, then backpressure
    run_word(8'hA5, 0, 1'b0, '0);
    run_word(8'h3C, 1, 1'b0, '0);

    // Reset mid-word after three accepted bits
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_bit", ser_out, 1);
      ser_ready = 1'b1;
      tick();
    end
    chk("abort_pre_valid", ser_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ser_valid", ser_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ser_out", ser_out, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #1;
    chk("abort_hold_done", done, 0);
    rst = 1'b0;
    ser_ready = 1'b0;
    tick();
    chk("abort_rel_done", done, 0);
    chk("abort_rel_ready", load_ready, 1);
    run_word(8'h01, 0, 1'b0, '0);

    // Load held high during a transfer is ignored until the next IDLE cycle
    run_word(8'h0F, 2, 1'b1, 8'h55);
    run_word(8'h55, 0, 1'b0, '0);

    // Randomized words with idle gaps
    for (int n = 0; n < 25; n++) begin
      run_word(WIDTH'($urandom), $urandom_range(0, 2), 1'b0, '0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk("gap_ready", load_ready, 1);
        chk("gap_done", done, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
